pc_stack_sequencer: RTL and testbench

Sequences the 13-bit program-counter return stack for the core: it turns CALL, RETURN, RETFIE and interrupt-entry requests into push/pop strobes on the return stack. It also produces the PC reload (target and strobe) and tracks stack depth, with sticky overflow and underflow flags. It sits between the instruction decoder/interrupt logic and the return stack instance.

---
 rtl/pc_stack_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_stack_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_sequencer.sv
// Return-stack sequencer: turns CALL/RETURN/RETFIE and interrupt entry into
// push/pop strobes and PC reloads, and tracks stack depth with sticky error flags.
module pc_stack_sequencer #(
  parameter int               WIDTH      = 13,
  parameter int               DEPTH_LOG2 = 3,
  parameter logic [WIDTH-1:0] INT_VECTOR = 13'h004
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [1:0]            op,
  output logic                  op_ready,
  input  logic [WIDTH-1:0]      ret_addr,
  input  logic [WIDTH-1:0]      call_target,
  input  logic                  irq_req,
  output logic                  irq_ack,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic [WIDTH-1:0]      stack_in,
  input  logic [WIDTH-1:0]      stack_top,
  output logic                  pc_load,
  output logic [WIDTH-1:0]      pc_target,
  output logic                  gie_clr,
  output logic                  gie_set,
  output logic [DEPTH_LOG2:0]   depth,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_flags
);

  typedef enum logic [1:0] {IDLE, PUSH, POP, LOAD} state_t;
  typedef enum logic [1:0] {K_CALL, K_RET, K_RETFIE, K_INT} kind_t;

  typedef struct packed {
    kind_t            kind;
    logic [WIDTH-1:0] ret;
    logic [WIDTH-1:0] tgt;
  } req_t;

  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  state_t state, state_nxt;
  req_t   req, req_nxt;
  logic   full, empty, ovf_set, unf_set;

  assign full    = (depth == FULL);
  assign empty   = (depth == '0);
  assign ovf_set = stack_push && full;
  assign unf_set = stack_pop && empty;

  always_comb begin
    state_nxt  = state;
    req_nxt    = req;
    op_ready   = 1'b0;
    irq_ack    = 1'b0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    stack_in   = '0;
    pc_load    = 1'b0;
    pc_target  = '0;
    gie_clr    = 1'b0;
    gie_set    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so nothing is acknowledged or accepted while held in reset.
        op_ready = rst && !irq_req;
        if (irq_req && rst) begin
          irq_ack      = 1'b1;
          req_nxt.kind = K_INT;
          req_nxt.ret  = ret_addr;
          req_nxt.tgt  = INT_VECTOR;
          state_nxt    = PUSH;
        end else if (op_valid && rst) begin
          case (op)
            2'b01: begin
              req_nxt.kind = K_CALL;
              req_nxt.ret  = ret_addr;
              req_nxt.tgt  = call_target;
              state_nxt    = PUSH;
            end
            2'b10: begin
              req_nxt.kind = K_RET;
              state_nxt    = POP;
            end
            2'b11: begin
              req_nxt.kind = K_RETFIE;
              state_nxt    = POP;
            end
            default: ;
          endcase
        end
      end
      PUSH: begin
        stack_push = 1'b1;
        stack_in   = req.ret;
        pc_load    = 1'b1;
        pc_target  = req.tgt;
        gie_clr    = (req.kind == K_INT);
        state_nxt  = IDLE;
      end
      POP: begin
        stack_pop = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        pc_load   = 1'b1;
        pc_target = stack_top;
        gie_set   = (req.kind == K_RETFIE);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req       <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      // Strobes still go out at the limits; only the count saturates.
      if (stack_push && !full)
        depth <= depth + ONE;
      else if (stack_pop && !empty)
        depth <= depth - ONE;
      if (ovf_set)
        overflow <= 1'b1;
      else if (clr_flags)
        overflow <= 1'b0;
      if (unf_set)
        underflow <= 1'b1;
      else if (clr_flags)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench for pc_stack_sequencer with a small behavioural return stack.
module tb_pc_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op;
  logic        op_ready;
  logic [12:0] ret_addr, call_target;
  logic        irq_req, irq_ack;
  logic        stack_push, stack_pop;
  logic [12:0] stack_in, stack_top;
  logic        pc_load;
  logic [12:0] pc_target;
  logic        gie_clr, gie_set;
  logic [3:0]  depth;
  logic        overflow, underflow;
  logic        clr_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_stack_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .ret_addr(ret_addr), .call_target(call_target), .irq_req(irq_req),
    .irq_ack(irq_ack), .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_in(stack_in), .stack_top(stack_top), .pc_load(pc_load),
    .pc_target(pc_target), .gie_clr(gie_clr), .gie_set(gie_set),
    .depth(depth), .overflow(overflow), .underflow(underflow),
    .clr_flags(clr_flags)
  );

  // Return stack model: a pop presents the most recently pushed entry next cycle.
  logic [12:0] mem [8];
  logic [2:0]  sp = 3'd0;
  logic [12:0] top_q = 13'd0;
  assign stack_top = top_q;
  initial for (int i = 0; i < 8; i++) mem[i] = 13'd0;

  always @(posedge clk) begin
    if (stack_push) begin
      mem[sp] <= stack_in;
      sp      <= sp + 3'd1;
    end else if (stack_pop) begin
      top_q <= mem[sp - 3'd1];
      sp    <= sp - 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " strobes"},
        {27'd0, stack_push, stack_pop, pc_load, gie_clr, gie_set}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; op = 2'b00; ret_addr = '0; call_target = '0;
    irq_req = 1'b0; clr_flags = 1'b0;
    #12;
    chk_quiet("reset");
    chk("reset depth", depth, 0);
    chk("reset flags", {overflow, underflow}, 0);
    chk("reset data", {pc_target, stack_in}, 0);
    chk("reset irq_ack", irq_ack, 0);
    tick; rst = 1'b1; #1;

    // op=00 is ignored
    op_valid = 1'b1; op = 2'b00; tick;
    chk("nop ready", op_ready, 1);
    chk_quiet("nop");

    // CALL
    op = 2'b01; ret_addr = 13'h0011; call_target = 13'h0200; #1;
    chk("call ready", op_ready, 1);
    tick; op_valid = 1'b0;
    chk("call push", stack_push, 1);
    chk("call stack_in", stack_in, 13'h0011);
    chk("call pc_load", pc_load, 1);
    chk("call pc_target", pc_target, 13'h0200);
    chk("call busy", op_ready, 0);
    chk("call gie_clr", gie_clr, 0);
    tick;
    chk("call depth", depth, 1);
    chk("call ready again", op_ready, 1);

    // RETURN, back-to-back
    op_valid = 1'b1; op = 2'b10; tick; op_valid = 1'b0;
    chk("ret pop", stack_pop, 1);
    chk("ret no load", pc_load, 0);
    chk("ret no push", stack_push, 0);
    tick;
    chk("ret pc_load", pc_load, 1);
    chk("ret pc_target", pc_target, 13'h0011);
    chk("ret gie_set", gie_set, 0);
    chk("ret depth", depth, 0);
    chk("ret busy", op_ready, 0);
    tick;
    chk("ret ready again", op_ready, 1);

    // Interrupt beats CALL
    irq_req = 1'b1; op_valid = 1'b1; op = 2'b01; ret_addr = 13'h0123; call_target = 13'h0777; #1;
    chk("irq ack", irq_ack, 1);
    chk("irq holds op", op_ready, 0);
    tick; irq_req = 1'b0; op_valid = 1'b0;
    chk("irq push", stack_push, 1);
    chk("irq stack_in", stack_in, 13'h0123);
    chk("irq pc_target", pc_target, 13'h0004);
    chk("irq gie_clr", gie_clr, 1);
    chk("irq ack pulse", irq_ack, 0);
    tick;
    chk("irq depth", depth, 1);
    op_valid = 1'b1; op = 2'b11; tick; op_valid = 1'b0;
    chk("retfie pop", stack_pop, 1);
    tick;
    chk("retfie gie_set", gie_set, 1);
    chk("retfie pc_target", pc_target, 13'h0123);
    tick;
    chk("retfie depth", depth, 0);

    // Nine CALLs: depth saturates, ninth push still strobed
    for (int i = 0; i < 9; i++) begin
      op_valid = 1'b1; op = 2'b01; ret_addr = 13'h0040 + 13'(i); call_target = 13'h0300 + 13'(i);
      tick; op_valid = 1'b0;
      if (i == 8) begin
        chk("ovf push", stack_push, 1);
        chk("ovf pc_target", pc_target, 13'h0308);
        chk("pre-ovf flag", overflow, 0);
      end
      tick;
    end
    chk("ovf depth", depth, 8);
    chk("ovf flag", overflow, 1);
    clr_flags = 1'b1; tick; clr_flags = 1'b0;
    chk("ovf clear", overflow, 0);
    chk("ovf depth hold", depth, 8);

    // Reset back to empty
    rst = 1'b0; #1;
    chk("rst depth", depth, 0);
    tick; rst = 1'b1; #1;

    // Underflow
    op_valid = 1'b1; op = 2'b10; tick; op_valid = 1'b0;
    chk("unf pop", stack_pop, 1);
    tick;
    chk("unf depth", depth, 0);
    chk("unf flag", underflow, 1);
    tick;
    clr_flags = 1'b1; tick; clr_flags = 1'b0;
    chk("unf clear", underflow, 0);
    op_valid = 1'b1; op = 2'b10; tick; op_valid = 1'b0;
    clr_flags = 1'b1; tick; clr_flags = 1'b0;
    chk("unf set wins", underflow, 1);
    chk("unf depth2", depth, 0);
    tick;
    clr_flags = 1'b1; tick; clr_flags = 1'b0;

    // Reset during the POP of a RETURN
    op_valid = 1'b1; op = 2'b01; ret_addr = 13'h0055; call_target = 13'h0100;
    tick; op_valid = 1'b0; tick;
    chk("abort pre depth", depth, 1);
    op_valid = 1'b1; op = 2'b10; tick; op_valid = 1'b0;
    chk("abort in pop", stack_pop, 1);
    rst = 1'b0; #1;
    chk_quiet("abort rst");
    chk("abort depth", depth, 0);
    chk("abort data", {pc_target, stack_in}, 0);
    tick; tick; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_quiet("after release");
      chk("after release depth", depth, 0);
    end
    chk("after release flags", {overflow, underflow}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
